// File: rtl/mod7177_mac35_if.sv
// Operand/result handshake bundle for the mod-7177 multiply-accumulate unit.
// The slave side is the MAC itself; the master side feeds operands and consumes sums.
interface mod7177_mac35_if;
    logic signed [12:0] InA;
    logic signed [12:0] InB;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic signed [34:0] Out;
    logic        [10:0] Count;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  InA, InB, in_last, in_valid, out_ready,
        output in_ready, Out, Count, out_err, out_valid
    );

    modport master (
        output InA, InB, in_last, in_valid, out_ready,
        input  in_ready, Out, Count, out_err, out_valid
    );
endinterface

// File: rtl/mod7177_mac35.sv
// Streaming signed multiply-accumulate: sums products of centered residues over a
// group of 1..MAXTERMS terms and hands out one 35-bit sum per group.
module mod7177_mac35 #(
    parameter int MAXTERMS = 1024,
    parameter int Q        = 7177
) (
    input  logic             clk,
    input  logic             Reset,
    mod7177_mac35_if.slave   bus
);

    localparam int HALF = (Q - 1) / 2;
    localparam logic signed [13:0] LIM_HI = 14'(HALF);
    localparam logic signed [13:0] LIM_LO = -14'(HALF);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        CLOSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               drain_reg;
    logic signed [25:0] prod_reg;
    logic signed [34:0] acc_reg;
    logic        [10:0] cnt_reg;
    logic               err_reg;
    logic signed [34:0] out_reg;
    logic        [10:0] count_reg;
    logic               out_err_reg;

    logic               accept;
    logic               closing;
    logic               load;
    logic        [10:0] cnt_inc;
    logic signed [25:0] product;
    logic signed [13:0] a_ext;
    logic signed [13:0] b_ext;
    logic               oor;

    assign accept  = bus.in_valid && (state_reg == ACC);
    assign cnt_inc = cnt_reg + 11'd1;
    assign closing = accept && (bus.in_last || (cnt_inc == 11'(MAXTERMS)));
    assign load    = (state_reg == CLOSE) && drain_reg;
    assign product = bus.InA * bus.InB;

    // Widen by one bit so the symmetric limit can be negated without overflow.
    assign a_ext = {bus.InA[12], bus.InA};
    assign b_ext = {bus.InB[12], bus.InB};
    assign oor   = (a_ext > LIM_HI) || (a_ext < LIM_LO) ||
                   (b_ext > LIM_HI) || (b_ext < LIM_LO);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACC:     if (closing)       state_next = CLOSE;
            CLOSE:   if (drain_reg)     state_next = HOLD;
            HOLD:    if (bus.out_ready) state_next = ACC;
            default:                    state_next = ACC;
        endcase
    end

    assign bus.in_ready  = (state_reg == ACC);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.Out       = out_reg;
    assign bus.Count     = count_reg;
    assign bus.out_err   = out_err_reg;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= ACC;
            drain_reg   <= 1'b0;
            prod_reg    <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            out_reg     <= '0;
            count_reg   <= '0;
            out_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            drain_reg <= (state_reg == CLOSE) && !drain_reg;
            // An idle cycle injects a zero product so the adder can run unconditionally.
            prod_reg  <= accept ? product : '0;
            if (load) begin
                out_reg     <= acc_reg;
                count_reg   <= cnt_reg;
                out_err_reg <= err_reg;
                acc_reg     <= '0;
                cnt_reg     <= '0;
                err_reg     <= 1'b0;
            end else begin
                acc_reg <= acc_reg + {{9{prod_reg[25]}}, prod_reg};
                if (accept) begin
                    cnt_reg <= cnt_inc;
                    err_reg <= err_reg | oor;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod7177_mac35.sv
// Randomised and directed checks of the mod-7177 MAC against a plain-arithmetic
// model of group sums, term counts and the per-group range flag.
module tb_mod7177_mac35;

    logic clk;
    logic Reset;
    int   n_vec;
    int   n_miss;

    mod7177_mac35_if bus ();

    mod7177_mac35 #(.MAXTERMS(1024), .Q(7177)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int centered(input longint v);
        longint r;
        r = v % 7177;
        if (r < 0) r += 7177;
        if (r > 3588) r -= 7177;
        return int'(r);
    endfunction

    task automatic send(input int a, input int b, input logic last);
        int w;
        bus.InA      = 13'(a);
        bus.InB      = 13'(b);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.out_valid && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) begin
            n_vec++;
            n_miss++;
            $display("FAIL out_valid_timeout out_valid=%0b required=1", bus.out_valid);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        bus.InA = '0; bus.InB = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Out !== 35'sd0 ||
            bus.Count !== 11'd0 || bus.out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state got rdy=%0b vld=%0b out=%0d cnt=%0d err=%0b required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.Out, bus.Count, bus.out_err);
        end
        Reset = 1'b1;
        bubble(1);
    endtask

    task automatic test_single_max();
        logic v0, v1, v2;
        send(3588, 3588, 1'b1);
        @(negedge clk); v0 = bus.out_valid;
        @(negedge clk); v1 = bus.out_valid;
        @(negedge clk); v2 = bus.out_valid;
        n_vec++;
        if ({v0, v1, v2} !== 3'b001) begin
            n_miss++;
            $display("FAIL single_latency got %b required 001", {v0, v1, v2});
        end
        n_vec++;
        if (bus.Out !== 35'sd12873744 || bus.Count !== 11'd1 || bus.out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL single_max got out=%0d cnt=%0d err=%0b required 12873744 1 0",
                     bus.Out, bus.Count, bus.out_err);
        end
        $display("single term: out=%0d cnt=%0d", bus.Out, bus.Count);
        handshake();
    endtask

    task automatic test_auto_close();
        longint exp_sum;
        int     rdy_high;
        exp_sum = 0;
        for (int i = 0; i < 1024; i++) begin
            send(-3588, 3588, 1'b0);
            exp_sum += longint'(-3588) * 3588;
        end
        rdy_high = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.in_ready) rdy_high++;
        end
        n_vec++;
        if (rdy_high != 0 || bus.out_valid !== 1'b1) begin
            n_miss++;
            $display("FAIL auto_close_ready in_ready_high_cycles=%0d out_valid=%0b required 0 1",
                     rdy_high, bus.out_valid);
        end
        n_vec++;
        if (bus.Out !== 35'(exp_sum) || bus.Count !== 11'd1024 || bus.out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL auto_close got out=%0d cnt=%0d err=%0b required %0d 1024 0",
                     bus.Out, bus.Count, bus.out_err, exp_sum);
        end
        $display("auto close: out=%0d cnt=%0d", bus.Out, bus.Count);
        handshake();
        @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL auto_close_release got rdy=%0b vld=%0b required 1 0",
                     bus.in_ready, bus.out_valid);
        end
        bubble(1);
    endtask

    task automatic test_bubbles_hold();
        int bad;
        send(1, 2, 1'b0);
        bubble(2);
        send(-3, 4, 1'b0);
        bubble(1);
        send(5, -6, 1'b1);
        wait_valid();
        n_vec++;
        if (bus.Out !== -35'sd40 || bus.Count !== 11'd3 || bus.out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL bubbles_sum got out=%0d cnt=%0d err=%0b required -40 3 0",
                     bus.Out, bus.Count, bus.out_err);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.Out !== -35'sd40 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_miss++;
            $display("FAIL hold_stable unstable_cycles=%0d required 0", bad);
        end
        $display("bubbles group: out=%0d cnt=%0d", bus.Out, bus.Count);
        bubble(0);
        #4;
        handshake();
    endtask

    task automatic test_err_flag();
        send(4000, 1, 1'b1);
        wait_valid();
        n_vec++;
        if (bus.Out !== 35'sd4000 || bus.out_err !== 1'b1) begin
            n_miss++;
            $display("FAIL err_set got out=%0d err=%0b required 4000 1", bus.Out, bus.out_err);
        end
        handshake();
        send(2, 2, 1'b1);
        wait_valid();
        n_vec++;
        if (bus.Out !== 35'sd4 || bus.out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL err_clear got out=%0d err=%0b required 4 0", bus.Out, bus.out_err);
        end
        $display("err groups done: out=%0d err=%0b", bus.Out, bus.out_err);
        handshake();
    endtask

    task automatic test_reset_mid_group();
        for (int i = 0; i < 10; i++) send(i + 1, 100, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.Count !== 11'd0 || bus.in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_mid got vld=%0b cnt=%0d rdy=%0b required 0 0 1",
                     bus.out_valid, bus.Count, bus.in_ready);
        end
        @(posedge clk);
        #1;
        Reset = 1'b1;
        bubble(1);
        send(7, 7, 1'b1);
        wait_valid();
        n_vec++;
        if (bus.Out !== 35'sd49 || bus.Count !== 11'd1 || bus.out_err !== 1'b0) begin
            n_miss++;
            $display("FAIL after_reset got out=%0d cnt=%0d err=%0b required 49 1 0",
                     bus.Out, bus.Count, bus.out_err);
        end
        $display("after reset: out=%0d cnt=%0d", bus.Out, bus.Count);
        handshake();
    endtask

    task automatic test_back_to_back();
        longint sum;
        int     n;
        int     a;
        int     b;
        logic   err;
        for (int g = 0; g < 40; g++) begin
            n   = $urandom_range(1, 12);
            sum = 0;
            err = 1'b0;
            for (int t = 0; t < n; t++) begin
                if ($urandom_range(0, 15) == 0) begin
                    a   = int'($urandom_range(3589, 4095));
                    if ($urandom_range(0, 1) == 1) a = -a;
                    err = 1'b1;
                end else begin
                    a = int'($urandom_range(0, 7176)) - 3588;
                end
                b = int'($urandom_range(0, 7176)) - 3588;
                sum += longint'(a) * b;
                send(a, b, t == n - 1);
                if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 2));
            end
            wait_valid();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_vec++;
            if (bus.Out !== 35'(sum) || bus.Count !== 11'(n) || bus.out_err !== err) begin
                n_miss++;
                $display("FAIL group%0d got out=%0d cnt=%0d err=%0b required %0d %0d %0b",
                         g, bus.Out, bus.Count, bus.out_err, sum, n, err);
            end
            n_vec++;
            if (centered(longint'(bus.Out)) != centered(sum)) begin
                n_miss++;
                $display("FAIL group%0d_residue got %0d required %0d",
                         g, centered(longint'(bus.Out)), centered(sum));
            end
            $display("group %0d: terms=%0d sum=%0d residue=%0d", g, n, sum, centered(sum));
            #4;
            handshake();
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_single_max();
        test_auto_close();
        test_bubbles_hold();
        test_err_flag();
        test_reset_mid_group();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
